// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked registered ALU with shift ops and iterative shift-add multiply
// Single-cycle ops land in DONE one edge after accept; MUL spends BUS_WIDTH edges in BUSY.
module alu_seq #(
  parameter int BUS_WIDTH   = 32,
  parameter int SHAMT_WIDTH = $clog2(BUS_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [BUS_WIDTH-1:0] num_0,
  input  logic [BUS_WIDTH-1:0] num_1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] num_out,
  output logic                 over_flag,
  output logic                 zero_flag,
  output logic                 greater_flag,
  output logic                 equal_flag
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;

  localparam int               CNT_W    = $clog2(BUS_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [BUS_WIDTH-1:0]     a_q;
  logic [2*BUS_WIDTH-1:0]   acc_q;
  logic                     gt_mul_q, eq_mul_q;
  logic [BUS_WIDTH-1:0]     num_out_q;
  logic                     over_q, zero_q, greater_q, equal_q;

  logic                     accept, is_mul, mul_last;
  logic [SHAMT_WIDTH-1:0]   shamt;
  logic [BUS_WIDTH:0]       sum_c;
  logic [2*BUS_WIDTH-1:0]   shl_c, shr_c;
  logic [BUS_WIDTH-1:0]     res_c;
  logic                     over_c;
  logic [BUS_WIDTH:0]       mul_sum;
  logic [2*BUS_WIDTH-1:0]   acc_next;

  assign accept   = in_valid && in_ready;
  assign is_mul   = (opcode == OP_MUL);
  assign mul_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_mul ? BUSY : DONE;
      BUSY:    if (mul_last) state_d = DONE;
      DONE: begin
        if (accept)         state_d = is_mul ? BUSY : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Shifts run through a double-width window so bits pushed out land in the other half.
  assign shamt = num_1[SHAMT_WIDTH-1:0];
  assign sum_c = {1'b0, num_0} + {1'b0, num_1};
  assign shl_c = {{BUS_WIDTH{1'b0}}, num_0} << shamt;
  assign shr_c = {num_0, {BUS_WIDTH{1'b0}}} >> shamt;

  always_comb begin
    res_c  = '0;
    over_c = 1'b0;
    case (opcode)
      OP_ADD: begin res_c = sum_c[BUS_WIDTH-1:0]; over_c = sum_c[BUS_WIDTH]; end
      OP_SUB: begin res_c = num_0 - num_1;        over_c = (num_0 < num_1);  end
      OP_XOR: res_c = num_0 ^ num_1;
      OP_AND: res_c = num_0 & num_1;
      OP_OR:  res_c = num_0 | num_1;
      OP_SHL: begin res_c = shl_c[BUS_WIDTH-1:0];           over_c = |shl_c[2*BUS_WIDTH-1:BUS_WIDTH]; end
      OP_SHR: begin res_c = shr_c[2*BUS_WIDTH-1:BUS_WIDTH]; over_c = |shr_c[BUS_WIDTH-1:0];           end
      default: ;
    endcase
  end

  // Multiplier sits in the low half of acc_q; partial product grows in the high half as it shifts right.
  assign mul_sum  = {1'b0, acc_q[2*BUS_WIDTH-1:BUS_WIDTH]}
                  + (acc_q[0] ? {1'b0, a_q} : {(BUS_WIDTH+1){1'b0}});
  assign acc_next = {mul_sum, acc_q[BUS_WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      a_q       <= '0;
      acc_q     <= '0;
      gt_mul_q  <= 1'b0;
      eq_mul_q  <= 1'b0;
      num_out_q <= '0;
      over_q    <= 1'b0;
      zero_q    <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        a_q      <= num_0;
        acc_q    <= {{BUS_WIDTH{1'b0}}, num_1};
        cnt_q    <= '0;
        gt_mul_q <= (num_0 > num_1);
        eq_mul_q <= (num_0 == num_1);
      end else begin
        num_out_q <= res_c;
        over_q    <= over_c;
        zero_q    <= (res_c == '0);
        greater_q <= (num_0 > num_1);
        equal_q   <= (num_0 == num_1);
      end
    end else if (state_q == BUSY) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q + 1'b1;
      if (mul_last) begin
        num_out_q <= acc_next[BUS_WIDTH-1:0];
        over_q    <= |acc_next[2*BUS_WIDTH-1:BUS_WIDTH];
        zero_q    <= (acc_next[BUS_WIDTH-1:0] == '0);
        greater_q <= gt_mul_q;
        equal_q   <= eq_mul_q;
      end
    end
  end

  assign num_out      = num_out_q;
  assign over_flag    = over_q;
  assign zero_flag    = zero_q;
  assign greater_flag = greater_q;
  assign equal_flag   = equal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

  localparam logic [3:0] OP_NUL = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [31:0] num_0, num_1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] num_out;
  logic        over_flag, zero_flag, greater_flag, equal_flag;

  int checks = 0;
  int errors = 0;

  logic [36:0] obs, exp;
  assign obs = {out_valid, num_out, over_flag, zero_flag, greater_flag, equal_flag};

  always #5 clk = ~clk;

  alu_seq #(.BUS_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .num_0        (num_0),
    .num_1        (num_1),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .num_out      (num_out),
    .over_flag    (over_flag),
    .zero_flag    (zero_flag),
    .greater_flag (greater_flag),
    .equal_flag   (equal_flag)
  );

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    opcode   = op;
    num_0    = a;
    num_1    = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = OP_NUL; num_0 = '0; num_1 = '0;
    #2;
    checks++; if (obs !== 37'h0) begin errors++; $display("FAIL reset_outputs: got %h, expected %h", obs, 37'h0); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++; if (obs !== 37'h0) begin errors++; $display("FAIL post_reset_outputs: got %h, expected %h", obs, 37'h0); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(OP_ADD, 32'hfffffff1, 32'h0000000f);
    tick();
    in_valid = 1'b0;
    exp = {1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL add_carry: got %h, expected %h", obs, exp); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_consumed: got %b, expected 0", out_valid); end
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    drive(OP_SUB, 32'h00000001, 32'hfffffff1);
    tick();
    exp = {1'b1, 32'h00000010, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL sub_borrow: got %h, expected %h", obs, exp); end
    drive(OP_SUB, 32'h0000ffff, 32'h0000ffff);
    tick();
    in_valid = 1'b0;
    exp = {1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL sub_equal: got %h, expected %h", obs, exp); end
    tick();
  endtask

  task automatic test_logic();
    out_ready = 1'b1;
    drive(OP_OR, 32'h0f0f0000, 32'h000000ff);
    tick();
    exp = {1'b1, 32'h0f0f00ff, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL or_op: got %h, expected %h", obs, exp); end
    drive(4'b1111, 32'h00000005, 32'h00000005);
    tick();
    exp = {1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL undefined_opcode: got %h, expected %h", obs, exp); end
    drive(OP_NUL, 32'h00000003, 32'h00000009);
    tick();
    in_valid = 1'b0;
    exp = {1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL nul_op: got %h, expected %h", obs, exp); end
    tick();
  endtask

  task automatic test_shift();
    out_ready = 1'b1;
    drive(OP_SHL, 32'h80000001, 32'h00000001);
    tick();
    exp = {1'b1, 32'h00000002, 1'b1, 1'b0, 1'b1, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL shl_by_1: got %h, expected %h", obs, exp); end
    drive(OP_SHR, 32'h80000001, 32'h0000001f);
    tick();
    exp = {1'b1, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL shr_by_31: got %h, expected %h", obs, exp); end
    drive(OP_SHL, 32'h12345678, 32'h00000020);
    tick();
    exp = {1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL shl_amount_wraps_to_0: got %h, expected %h", obs, exp); end
    drive(OP_SHR, 32'h12345678, 32'h00000000);
    tick();
    in_valid = 1'b0;
    exp = {1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL shr_by_0: got %h, expected %h", obs, exp); end
    tick();
  endtask

  task automatic test_mul();
    int cyc;
    out_ready = 1'b1;
    drive(OP_MUL, 32'h00010000, 32'h00010000);
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != 32) begin errors++; $display("FAIL mul_latency_1: got %0d cycles, expected 32", cyc); end
    exp = {1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL mul_high_product: got %h, expected %h", obs, exp); end
    drive(OP_MUL, 32'h0000ffff, 32'h0000ffff);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_busy_valid: got %b, expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_in_ready: got %b, expected 0", in_ready); end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != 32) begin errors++; $display("FAIL mul_latency_2: got %0d cycles, expected 32", cyc); end
    exp = {1'b1, 32'hfffe0001, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL mul_ffff_sq: got %h, expected %h", obs, exp); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(OP_XOR, 32'h7e7e7e7e, 32'h5555aaaa);
    tick();
    drive(OP_AND, 32'hf0f0f0f0, 32'hff00ff00);
    exp = {1'b1, 32'h2b2bd4d4, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      checks++; if (obs !== exp) begin errors++; $display("FAIL bp_hold[%0d]: got %h, expected %h", i, obs, exp); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b, expected 0", i, in_ready); end
      tick();
    end
    checks++; if (obs !== exp) begin errors++; $display("FAIL bp_hold_end: got %h, expected %h", obs, exp); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b, expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    exp = {1'b1, 32'hf000f000, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL bp_and_follows: got %h, expected %h", obs, exp); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b, expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    out_ready = 1'b1;
    drive(OP_ADD, 32'h00000005, 32'h00000005);
    tick();
    drive(OP_MUL, 32'h00000003, 32'h00000005);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    exp = {1'b0, 32'h0000000a, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL mid_mul_state: got %h, expected %h", obs, exp); end
    rst_n = 1'b0;
    #1;
    checks++; if (obs !== 37'h0) begin errors++; $display("FAIL mid_mul_reset_outputs: got %h, expected %h", obs, 37'h0); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_mul_reset_in_ready: got %b, expected 1", in_ready); end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_mul_stale_result: got %b, expected 0", seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_mul_post_in_ready: got %b, expected 1", in_ready); end
    drive(OP_ADD, 32'h00000001, 32'h00000002);
    tick();
    in_valid = 1'b0;
    exp = {1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL mid_mul_recover_add: got %h, expected %h", obs, exp); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
